// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the memory controller CPU port between the
// instruction-fetch and load/store requesters; rejects misaligned data accesses.
module mem_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [DATA_WIDTH-1:0] if_addr,
    output logic                  if_ready,
    output logic                  if_resp_valid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_store,
    input  logic [DATA_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [1:0]            d_length,
    input  logic                  d_unsigned,
    output logic                  d_ready,
    output logic                  d_resp_valid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_err,
    output logic [DATA_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [1:0]            mem_length,
    output logic                  mem_unsigned,
    output logic                  mem_store,
    output logic                  mem_load,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ERROR  = 2'd2
    } state_t;

    localparam logic       OWNER_FETCH = 1'b0;
    localparam logic       OWNER_DATA  = 1'b1;
    localparam logic [2:0] LAT_M1      = 3'(READ_LATENCY - 1);

    // Length 2 is never legal; halves need even and words need 4-byte alignment.
    function automatic logic misaligned(input logic [1:0] len, input logic [1:0] addr_lo);
        logic bad;
        case (len)
            2'd0:    bad = 1'b0;
            2'd1:    bad = addr_lo[0];
            2'd3:    bad = (addr_lo != 2'd0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  owner_q, owner_d;
    logic                  is_store_q, is_store_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]            mem_length_q, mem_length_d;
    logic                  mem_unsigned_q, mem_unsigned_d;
    logic                  if_resp_valid_q, if_resp_valid_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic                  d_resp_valid_q, d_resp_valid_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  d_err_q, d_err_d;
    logic                  grant_if_s, grant_d_s;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        grant_if_s = (state_q == ST_IDLE) && if_req && (!d_req || (last_grant_q == OWNER_DATA));
        grant_d_s  = (state_q == ST_IDLE) && d_req && (!if_req || (last_grant_q == OWNER_FETCH));
    end

    assign if_ready      = grant_if_s;
    assign d_ready       = grant_d_s;
    assign mem_load      = (state_q == ST_ACCESS) && !is_store_q;
    assign mem_store     = (state_q == ST_ACCESS) && is_store_q;
    assign mem_address   = mem_address_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_length    = mem_length_q;
    assign mem_unsigned  = mem_unsigned_q;
    assign if_resp_valid = if_resp_valid_q;
    assign if_rdata      = if_rdata_q;
    assign d_resp_valid  = d_resp_valid_q;
    assign d_rdata       = d_rdata_q;
    assign d_err         = d_err_q;

    // Next-state and access sequencing.
    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        owner_d         = owner_q;
        is_store_d      = is_store_q;
        cnt_d           = cnt_q;
        mem_address_d   = mem_address_q;
        mem_wdata_d     = mem_wdata_q;
        mem_length_d    = mem_length_q;
        mem_unsigned_d  = mem_unsigned_q;
        if_resp_valid_d = 1'b0;
        if_rdata_d      = if_rdata_q;
        d_resp_valid_d  = 1'b0;
        d_rdata_d       = d_rdata_q;
        d_err_d         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_if_s) begin
                    owner_d        = OWNER_FETCH;
                    last_grant_d   = OWNER_FETCH;
                    is_store_d     = 1'b0;
                    cnt_d          = LAT_M1;
                    mem_address_d  = if_addr;
                    mem_length_d   = 2'd3;
                    mem_unsigned_d = 1'b1;
                    state_d        = ST_ACCESS;
                end else if (grant_d_s) begin
                    owner_d      = OWNER_DATA;
                    last_grant_d = OWNER_DATA;
                    if (misaligned(d_length, d_addr[1:0])) begin
                        state_d = ST_ERROR;
                    end else begin
                        is_store_d     = d_store;
                        cnt_d          = LAT_M1;
                        mem_address_d  = d_addr;
                        mem_wdata_d    = d_wdata;
                        mem_length_d   = d_length;
                        mem_unsigned_d = d_unsigned;
                        state_d        = ST_ACCESS;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (is_store_q) begin
                    d_resp_valid_d = 1'b1;
                    d_rdata_d      = '0;
                    state_d        = ST_IDLE;
                end else if (cnt_q == 3'd0) begin
                    if (owner_q == OWNER_FETCH) begin
                        if_resp_valid_d = 1'b1;
                        if_rdata_d      = mem_rdata;
                    end else begin
                        d_resp_valid_d = 1'b1;
                        d_rdata_d      = mem_rdata;
                    end
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_ERROR: begin
                d_resp_valid_d = 1'b1;
                d_rdata_d      = '0;
                d_err_d        = 1'b1;
                state_d        = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            last_grant_q    <= OWNER_DATA;
            owner_q         <= OWNER_FETCH;
            is_store_q      <= 1'b0;
            cnt_q           <= 3'd0;
            mem_address_q   <= '0;
            mem_wdata_q     <= '0;
            mem_length_q    <= 2'd0;
            mem_unsigned_q  <= 1'b0;
            if_resp_valid_q <= 1'b0;
            if_rdata_q      <= '0;
            d_resp_valid_q  <= 1'b0;
            d_rdata_q       <= '0;
            d_err_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            owner_q         <= owner_d;
            is_store_q      <= is_store_d;
            cnt_q           <= cnt_d;
            mem_address_q   <= mem_address_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_length_q    <= mem_length_d;
            mem_unsigned_q  <= mem_unsigned_d;
            if_resp_valid_q <= if_resp_valid_d;
            if_rdata_q      <= if_rdata_d;
            d_resp_valid_q  <= d_resp_valid_d;
            d_rdata_q       <= d_rdata_d;
            d_err_q         <= d_err_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a scoreboard of expected responses
// and a monitor checking the controller-side sequencing of every access.
module tb_mem_port_arbiter;
    localparam int DW = 32;
    localparam int RL = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, if_ready, if_resp_valid;
    logic [DW-1:0] if_addr, if_rdata;
    logic          d_req, d_store, d_unsigned, d_ready, d_resp_valid, d_err;
    logic [DW-1:0] d_addr, d_wdata, d_rdata;
    logic [1:0]    d_length;
    logic [DW-1:0] mem_address, mem_wdata, mem_rdata;
    logic [1:0]    mem_length;
    logic          mem_unsigned, mem_store, mem_load;

    mem_port_arbiter #(.DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_store(d_store), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_length(d_length), .d_unsigned(d_unsigned), .d_ready(d_ready),
        .d_resp_valid(d_resp_valid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_length(mem_length),
        .mem_unsigned(mem_unsigned), .mem_store(mem_store), .mem_load(mem_load),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] model(input logic [DW-1:0] a);
        return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_0000);
    endfunction
    assign mem_rdata = model(mem_address);

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          store;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [1:0]    len;
        logic          uns;
        int            t0;
    } exp_t;

    exp_t if_q[$];
    exp_t d_q[$];
    exp_t acc;
    int   cyc = 0;
    int   ld_cnt = 0;
    int   st_cnt = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_mis(input logic [1:0] len, input logic [DW-1:0] a);
        return (len == 2'd2) || (len == 2'd1 && a[0]) || (len == 2'd3 && a[1:0] != 2'b00);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: exclusion, controller-port contents, response scoreboard, grants.
    always @(negedge clk) begin
        if (!reset) begin
            chk("ready_excl", 32'(if_ready & d_ready), 32'd0);
            chk("ld_st_excl", 32'(mem_load & mem_store), 32'd0);
            if (mem_load || mem_store) begin
                chk("mem_address", mem_address, acc.addr);
                chk("mem_length", 32'(mem_length), 32'(acc.len));
                chk("mem_unsigned", 32'(mem_unsigned), 32'(acc.uns));
                chk("mem_store_kind", 32'(mem_store), 32'(acc.store));
                if (mem_store) chk("mem_wdata", mem_wdata, acc.wdata);
                if (mem_load) ld_cnt++;
                if (mem_store) st_cnt++;
            end
            if (if_resp_valid) begin
                if (if_q.size() == 0) chk("if_unexpected_resp", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = if_q.pop_front();
                    chk("if_rdata", if_rdata, e.rdata);
                    chk("if_latency", 32'(cyc - e.t0), 32'(RL + 1));
                    chk("if_load_cycles", 32'(ld_cnt), 32'(RL));
                end
            end
            if (d_resp_valid) begin
                if (d_q.size() == 0) chk("d_unexpected_resp", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = d_q.pop_front();
                    chk("d_rdata", d_rdata, e.rdata);
                    chk("d_err", 32'(d_err), 32'(e.err));
                    chk("d_latency", 32'(cyc - e.t0), (e.err || e.store) ? 32'd2 : 32'(RL + 1));
                    chk("d_load_cycles", 32'(ld_cnt), (e.err || e.store) ? 32'd0 : 32'(RL));
                    chk("d_store_cycles", 32'(st_cnt), (!e.err && e.store) ? 32'd1 : 32'd0);
                end
            end
            if (if_ready) begin
                exp_t e;
                e = '{rdata: model(if_addr), err: 1'b0, store: 1'b0, addr: if_addr,
                      wdata: '0, len: 2'd3, uns: 1'b1, t0: cyc};
                if_q.push_back(e);
                acc = e; ld_cnt = 0; st_cnt = 0;
            end
            if (d_ready) begin
                exp_t e;
                logic bad;
                bad = is_mis(d_length, d_addr);
                e = '{rdata: (bad || d_store) ? '0 : model(d_addr), err: bad, store: d_store,
                      addr: d_addr, wdata: d_wdata, len: d_length, uns: d_unsigned, t0: cyc};
                d_q.push_back(e);
                acc = e; ld_cnt = 0; st_cnt = 0;
            end
        end
    end

    task automatic wait_idle();
        int i;
        for (i = 0; i < 60; i++) begin
            @(negedge clk);
            if (if_q.size() == 0 && d_q.size() == 0) break;
        end
        chk("resp_timeout", 32'(i < 60), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_fetch(input logic [DW-1:0] a);
        int i;
        if_req = 1'b1; if_addr = a;
        for (i = 0; i < 60; i++) begin
            @(negedge clk);
            if (if_ready) break;
        end
        chk("if_ready_timeout", 32'(i < 60), 32'd1);
        @(posedge clk); #1;
        if_req = 1'b0; if_addr = 32'hFFFF_FFFF;
        wait_idle();
    endtask

    task automatic do_data(input logic st, input logic [DW-1:0] a, input logic [DW-1:0] wd,
                           input logic [1:0] len, input logic uns);
        int i;
        d_req = 1'b1; d_store = st; d_addr = a; d_wdata = wd; d_length = len; d_unsigned = uns;
        for (i = 0; i < 60; i++) begin
            @(negedge clk);
            if (d_ready) break;
        end
        chk("d_ready_timeout", 32'(i < 60), 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0; d_addr = 32'hFFFF_FFFF; d_wdata = 32'hFFFF_FFFF; d_length = 2'd3;
        wait_idle();
    endtask

    task automatic check_all_zero();
        chk("rst_if_ready", 32'(if_ready), 32'd0);
        chk("rst_d_ready", 32'(d_ready), 32'd0);
        chk("rst_if_resp", 32'(if_resp_valid), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_resp", 32'(d_resp_valid), 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_d_err", 32'(d_err), 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_length", 32'(mem_length), 32'd0);
        chk("rst_mem_unsigned", 32'(mem_unsigned), 32'd0);
        chk("rst_mem_load", 32'(mem_load), 32'd0);
        chk("rst_mem_store", 32'(mem_store), 32'd0);
    endtask

    initial begin
        byte grants[$];
        byte exp_order[4];
        exp_order = '{8'h46, 8'h44, 8'h46, 8'h44};
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_store = 1'b0; d_addr = '0; d_wdata = '0; d_length = 2'd0; d_unsigned = 1'b0;
        #12;
        check_all_zero();
        @(posedge clk); #1;
        reset = 1'b0;

        // Contention: first tie goes to fetch, then strict alternation.
        if_req = 1'b1; if_addr = 32'h0000_0100;
        d_req = 1'b1; d_store = 1'b0; d_addr = 32'h0000_0040; d_length = 2'd3; d_unsigned = 1'b0;
        for (int i = 0; i < 60 && grants.size() < 4; i++) begin
            @(negedge clk);
            if (if_ready) grants.push_back(8'h46);
            if (d_ready) grants.push_back(8'h44);
        end
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;
        chk("grant_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            chk($sformatf("grant_order_%0d", i), 32'(grants[i]), 32'(exp_order[i]));
        wait_idle();

        do_fetch(32'h0000_0100);
        do_data(1'b1, 32'h0000_0203, 32'h0000_00AB, 2'd0, 1'b0);
        do_data(1'b0, 32'h0000_0202, 32'h0, 2'd3, 1'b0);
        do_data(1'b0, 32'h0000_0201, 32'h0, 2'd1, 1'b1);
        do_data(1'b1, 32'h0000_0200, 32'h1234_5678, 2'd2, 1'b0);
        do_data(1'b0, 32'h0000_0202, 32'h0, 2'd1, 1'b1);
        do_data(1'b1, 32'h0000_0208, 32'hCAFE_F00D, 2'd3, 1'b0);
        do_data(1'b0, 32'h0000_0044, 32'h0, 2'd3, 1'b0);

        // Asynchronous reset mid-cycle while outputs hold nonzero values.
        #3 reset = 1'b1;
        #1 check_all_zero();
        if_q.delete(); d_q.delete();
        @(posedge clk); #1 reset = 1'b0;

        // Reset during a load ACCESS abandons it without a response.
        if_req = 1'b1; if_addr = 32'h0000_0300;
        @(negedge clk);
        chk("pre_abort_ready", 32'(if_ready), 32'd1);
        @(posedge clk); #1;
        if_req = 1'b0;
        chk("abort_in_access", 32'(mem_load), 32'd1);
        #2 reset = 1'b1;
        #1 chk("abort_mem_load", 32'(mem_load), 32'd0);
        if_q.delete(); d_q.delete();
        @(posedge clk); #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1 do_fetch(32'h0000_0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
